// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix-multiply operand feeder:
//   - mm_state_e : feeder sequencing states
//   - cnt_width  : width of the beat/slot counter for an N-slot job
// -----------------------------------------------------------------------------
package mm_pkg;

  // Job sequencing: flush engine, collect N beats, replay N beats,
  // wait for the engine, hold the result until the consumer takes it.
  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } mm_state_e;

  // Counter width for indexing N slots; never narrower than one bit so the
  // counter stays a legal vector for any N.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : mm_pkg

// File: rtl/mm_operand_buffer.sv
// -----------------------------------------------------------------------------
// mm_operand_buffer
// N-slot register file holding one job's operands. Slot k holds column k of
// A and row k of B, exactly as they arrived on the load port.
//
// Ports
//   clk       : clock, write on rising edge
//   i_wr_en   : write strobe (one accepted load beat)
//   i_wr_idx  : slot written by the strobe
//   i_wr_a    : A column to store
//   i_wr_b    : B row to store
//   i_rd_idx  : slot presented on the read port (combinational read)
//   o_rd_a    : A column of slot i_rd_idx (zero when the index is out of range)
//   o_rd_b    : B row of slot i_rd_idx (zero when the index is out of range)
// -----------------------------------------------------------------------------
module mm_operand_buffer
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int CW         = cnt_width(N)
) (
  input  logic                             clk,
  input  logic                             i_wr_en,
  input  logic [CW-1:0]                    i_wr_idx,
  input  logic [N-1:0][DATA_WIDTH-1:0]     i_wr_a,
  input  logic [N-1:0][DATA_WIDTH-1:0]     i_wr_b,
  input  logic [CW-1:0]                    i_rd_idx,
  output logic [N-1:0][DATA_WIDTH-1:0]     o_rd_a,
  output logic [N-1:0][DATA_WIDTH-1:0]     o_rd_b
);

  logic [N-1:0][DATA_WIDTH-1:0] r_slot_a [N];
  logic [N-1:0][DATA_WIDTH-1:0] r_slot_b [N];

  // NOTE: storage has no reset on purpose; every slot is rewritten before it
  // is read in a job, and skipping the reset keeps this a plain flop array.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_slot_a[i_wr_idx] <= i_wr_a;
      r_slot_b[i_wr_idx] <= i_wr_b;
    end
  end

  // NOTE: assign defaults first in combinational blocks so no path leaves an
  // output unassigned (which would infer a latch).
  always_comb begin
    o_rd_a = '0;
    o_rd_b = '0;
    for (int s = 0; s < N; s++) begin
      if (i_rd_idx == CW'(s)) begin
        o_rd_a = r_slot_a[s];
        o_rd_b = r_slot_b[s];
      end
    end
  end

endmodule : mm_operand_buffer

// File: rtl/mm_operand_feeder.sv
// -----------------------------------------------------------------------------
// mm_operand_feeder
// Collects N operand beats (A column k, B row k) from a valid/ready load port,
// then replays them to an outer-product matrix-multiply engine as N
// back-to-back valid cycles, waits for the engine to finish, and holds the
// engine result visible (done_o) until the consumer acknowledges it. Each new
// job starts with a one-cycle engine reset so the accumulators begin at zero.
//
// Ports
//   clk           : clock, all state on rising edge
//   reset_ni      : asynchronous active-low reset, aborts any job
//   load_valid_i  : load beat offered
//   load_ready_o  : feeder can accept a beat (LOAD only)
//   load_a_i      : column k of A, element i = A[i][k]
//   load_b_i      : row k of B, element j = B[k][j]
//   mm_valid_o    : engine valid_i, high for exactly N cycles per job
//   mm_a_o        : engine a_i (zero when mm_valid_o is low)
//   mm_b_o        : engine b_i (zero when mm_valid_o is low)
//   mm_reset_o    : engine synchronous reset, one cycle per job and in reset
//   mm_done_i     : engine valid_o
//   done_o        : engine result valid for the consumer (HOLD only)
//   result_ack_i  : consumer has taken the result
//   err_o         : sticky flag, engine reported done while feeding
// -----------------------------------------------------------------------------
module mm_operand_feeder
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                             clk,
  input  logic                             reset_ni,
  input  logic                             load_valid_i,
  output logic                             load_ready_o,
  input  logic [N-1:0][DATA_WIDTH-1:0]     load_a_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]     load_b_i,
  output logic                             mm_valid_o,
  output logic [N-1:0][DATA_WIDTH-1:0]     mm_a_o,
  output logic [N-1:0][DATA_WIDTH-1:0]     mm_b_o,
  output logic                             mm_reset_o,
  input  logic                             mm_done_i,
  output logic                             done_o,
  input  logic                             result_ack_i,
  output logic                             err_o
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mm_state_e                    r_state;
  logic [CW-1:0]                r_cnt;
  logic                         r_load_ready;
  logic                         r_mm_valid;
  logic [N-1:0][DATA_WIDTH-1:0] r_mm_a;
  logic [N-1:0][DATA_WIDTH-1:0] r_mm_b;
  logic                         r_mm_reset;
  logic                         r_done;
  logic                         r_err;

  logic                         w_load_hs;
  logic [CW-1:0]                w_rd_idx;
  logic [N-1:0][DATA_WIDTH-1:0] w_rd_a;
  logic [N-1:0][DATA_WIDTH-1:0] w_rd_b;

  // Ready is only ever high in LOAD, so this is the accepted-beat strobe.
  assign w_load_hs = r_load_ready & load_valid_i;

  // Stream outputs are registered, so the read port looks one slot ahead:
  // slot 0 while the last beat is being accepted, slot cnt+1 while streaming.
  always_comb begin
    w_rd_idx = '0;
    if (r_state == STREAM) begin
      w_rd_idx = r_cnt + 1'b1;
    end
  end

  mm_operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N)
  ) u_buffer (
    .clk      (clk),
    .i_wr_en  (w_load_hs),
    .i_wr_idx (r_cnt),
    .i_wr_a   (load_a_i),
    .i_wr_b   (load_b_i),
    .i_rd_idx (w_rd_idx),
    .o_rd_a   (w_rd_a),
    .o_rd_b   (w_rd_b)
  );

  // NOTE: every register here is written with <= so all of them update
  // together from pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= CLEAR;
      r_cnt        <= '0;
      r_load_ready <= 1'b0;
      r_mm_valid   <= 1'b0;
      r_mm_a       <= '0;
      r_mm_b       <= '0;
      r_mm_reset   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // An engine result while operands are still going in means the engine
      // and feeder disagree about the job; flag it but keep sequencing.
      if (mm_done_i && (r_state == LOAD || r_state == STREAM)) begin
        r_err <= 1'b1;
      end

      case (r_state)
        CLEAR: begin
          r_mm_reset   <= 1'b0;
          r_cnt        <= '0;
          r_load_ready <= 1'b1;
          r_state      <= LOAD;
        end

        LOAD: begin
          if (w_load_hs) begin
            if (r_cnt == LAST) begin
              r_cnt        <= '0;
              r_load_ready <= 1'b0;
              r_mm_valid   <= 1'b1;
              r_mm_a       <= w_rd_a;
              r_mm_b       <= w_rd_b;
              r_state      <= STREAM;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        STREAM: begin
          if (r_cnt == LAST) begin
            r_cnt      <= '0;
            r_mm_valid <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_state    <= WAIT;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_mm_a <= w_rd_a;
            r_mm_b <= w_rd_b;
          end
        end

        WAIT: begin
          if (mm_done_i) begin
            r_done  <= 1'b1;
            r_state <= HOLD;
          end
        end

        HOLD: begin
          // Engine stays out of reset here so its result remains visible.
          if (result_ack_i) begin
            r_done     <= 1'b0;
            r_mm_reset <= 1'b1;
            r_state    <= CLEAR;
          end
        end

        default: begin
          r_cnt        <= '0;
          r_load_ready <= 1'b0;
          r_mm_valid   <= 1'b0;
          r_mm_a       <= '0;
          r_mm_b       <= '0;
          r_mm_reset   <= 1'b1;
          r_done       <= 1'b0;
          r_state      <= CLEAR;
        end
      endcase
    end
  end

  assign load_ready_o = r_load_ready;
  assign mm_valid_o   = r_mm_valid;
  assign mm_a_o       = r_mm_a;
  assign mm_b_o       = r_mm_b;
  assign mm_reset_o   = r_mm_reset;
  assign done_o       = r_done;
  assign err_o        = r_err;

  // Invariants of the output protocol.
  a_phase_exclusive : assert property (@(posedge clk) disable iff (!reset_ni)
    $onehot0({r_load_ready, r_mm_valid, r_done}));

  a_idle_data_zero : assert property (@(posedge clk) disable iff (!reset_ni)
    !r_mm_valid |-> (r_mm_a == '0 && r_mm_b == '0));

  a_done_in_hold : assert property (@(posedge clk) disable iff (!reset_ni)
    r_done == (r_state == HOLD));

endmodule : mm_operand_feeder

// File: tb/tb_mm_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_mm_operand_feeder
// Drives mm_operand_feeder with directed jobs (N=4, DATA_WIDTH=8) and a small
// behavioural outer-product engine. A job-level model predicts every output
// on every cycle; literal expectations pin latency, reset values and results.
// -----------------------------------------------------------------------------
module tb_mm_operand_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset_ni;
  logic load_valid_i;
  logic load_ready_o;
  vec_t load_a_i;
  vec_t load_b_i;
  logic mm_valid_o;
  vec_t mm_a_o;
  vec_t mm_b_o;
  logic mm_reset_o;
  logic mm_done_i;
  logic done_o;
  logic result_ack_i;
  logic err_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en;

  always #5 clk = ~clk;

  mm_operand_feeder #(
    .DATA_WIDTH (DW),
    .N          (N)
  ) dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_a_i     (load_a_i),
    .load_b_i     (load_b_i),
    .mm_valid_o   (mm_valid_o),
    .mm_a_o       (mm_a_o),
    .mm_b_o       (mm_b_o),
    .mm_reset_o   (mm_reset_o),
    .mm_done_i    (mm_done_i),
    .done_o       (done_o),
    .result_ack_i (result_ack_i),
    .err_o        (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural engine: C += a (outer) b, done 3N-2 after first valid
  logic e_started, e_done, inj_done;
  int   e_t;
  int   e_c [N][N];

  assign mm_done_i = e_done | inj_done;

  always @(posedge clk) begin
    if (mm_reset_o) begin
      e_started <= 1'b0;
      e_done    <= 1'b0;
      e_t       <= 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          e_c[i][j] <= 0;
    end else begin
      if (mm_valid_o)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            e_c[i][j] <= e_c[i][j] + int'(mm_a_o[i]) * int'(mm_b_o[j]);
      if (mm_valid_o && !e_started) begin
        e_started <= 1'b1;
        e_t       <= 1;
      end else if (e_started && !e_done) begin
        if (e_t == 3 * N - 3) e_done <= 1'b1;
        e_t <= e_t + 1;
      end
    end
  end

  // ---------------- job-level model: beats taken, beats streamed, result seen
  logic m_clear, m_done_seen, m_err;
  int   m_beats, m_streamed;
  vec_t m_buf_a [N];
  vec_t m_buf_b [N];

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_clear     <= 1'b1;
      m_beats     <= 0;
      m_streamed  <= 0;
      m_done_seen <= 1'b0;
      m_err       <= 1'b0;
    end else if (m_clear) begin
      m_clear     <= 1'b0;
      m_beats     <= 0;
      m_streamed  <= 0;
      m_done_seen <= 1'b0;
    end else if (m_beats < N) begin
      if (load_valid_i) begin
        m_buf_a[m_beats] <= load_a_i;
        m_buf_b[m_beats] <= load_b_i;
        m_beats          <= m_beats + 1;
      end
      if (mm_done_i) m_err <= 1'b1;
    end else if (m_streamed < N) begin
      m_streamed <= m_streamed + 1;
      if (mm_done_i) m_err <= 1'b1;
    end else if (!m_done_seen) begin
      if (mm_done_i) m_done_seen <= 1'b1;
    end else if (result_ack_i) begin
      m_clear <= 1'b1;
    end
  end

  logic exp_ready, exp_valid, exp_done;
  vec_t exp_a, exp_b;
  always_comb begin
    exp_ready = !m_clear && (m_beats < N);
    exp_valid = !m_clear && (m_beats == N) && (m_streamed < N);
    exp_done  = !m_clear && (m_beats == N) && (m_streamed == N) && m_done_seen;
    exp_a     = '0;
    exp_b     = '0;
    if (exp_valid) begin
      exp_a = m_buf_a[m_streamed];
      exp_b = m_buf_b[m_streamed];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_mm_reset", mm_reset_o, m_clear);
      check("cyc_ready", load_ready_o, exp_ready);
      check("cyc_valid", mm_valid_o, exp_valid);
      check("cyc_a", mm_a_o, exp_a);
      check("cyc_b", mm_b_o, exp_b);
      check("cyc_done", done_o, exp_done);
      check("cyc_err", err_o, m_err);
    end
  end

  // ---------------- stimulus helpers
  int ta  [N][N];   // A[i][k]
  int tbm [N][N];   // B[k][j]

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ta[i][j]  = (i == j) ? 1 : 0;
        tbm[i][j] = i * N + j + 1;
      end
  endtask

  task automatic set_pattern(input int seed);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ta[i][j]  = (i * 3 + j * 5 + seed) % 13 + 1;
        tbm[i][j] = (i * 7 + j * 2 + seed) % 11 + 2;
      end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) begin
      load_a_i[i] = DW'(ta[i][k]);
      load_b_i[i] = DW'(tbm[k][i]);
    end
  endtask

  // Back-to-back load; inj_beat >= 0 pulses mm_done_i during that beat.
  task automatic load_b2b(input int inj_beat);
    for (int k = 0; k < N; k++) begin
      drive_beat(k);
      load_valid_i = 1'b1;
      inj_done     = (k == inj_beat);
      tick();
      inj_done = 1'b0;
      if (k == inj_beat) check("err_set_in_load", err_o, 1);
    end
    load_valid_i = 1'b0;
    load_a_i     = '0;
    load_b_i     = '0;
  endtask

  task automatic check_product();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += ta[i][k] * tbm[k][j];
        check("c_elem", e_c[i][j], s);
      end
  endtask

  // Waits (bounded) for done_o, counting cycles; checks result and acks.
  task automatic finish_job(output int n);
    n = 0;
    while (!done_o && n < 60) begin
      tick();
      n++;
    end
    check("done_seen", done_o, 1);
    check_product();
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
    tick();
  endtask

  task automatic release_reset();
    reset_ni = 1'b1;
    check("clear_mm_reset", mm_reset_o, 1);
    check("clear_ready", load_ready_o, 0);
    tick();
    check("load_ready", load_ready_o, 1);
    check("load_mm_reset", mm_reset_o, 0);
  endtask

  int pat [6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    int n;
    int k;
    reset_ni     = 1'b0;
    load_valid_i = 1'b0;
    load_a_i     = '0;
    load_b_i     = '0;
    result_ack_i = 1'b0;
    inj_done     = 1'b0;
    cmp_en       = 1'b0;

    // Reset held three cycles.
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    check("rst_mm_reset", mm_reset_o, 1);
    check("rst_ready", load_ready_o, 0);
    check("rst_valid", mm_valid_o, 0);
    check("rst_done", done_o, 0);
    release_reset();

    // Identity A, B = 1..16, back-to-back.
    set_identity();
    load_b2b(-1);
    check("first_valid", mm_valid_o, 1);
    check("first_a", mm_a_o, 32'h0000_0001);
    check("first_b", mm_b_o, 32'h0403_0201);
    n = 0;
    while (!done_o && n < 60) begin
      tick();
      n++;
    end
    check("done_latency", n, 3 * N - 1);
    check("c_lit_00", e_c[0][0], 1);
    check("c_lit_12", e_c[1][2], 7);
    check("c_lit_33", e_c[3][3], 16);
    check_product();

    // Hold with no ack for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("hold_done", done_o, 1);
      check("hold_mm_reset", mm_reset_o, 0);
    end
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
    check("ack_mm_reset", mm_reset_o, 1);
    check("ack_ready", load_ready_o, 0);
    check("ack_done", done_o, 0);
    tick();
    check("ack_then_ready", load_ready_o, 1);

    // Gapped load 1,0,1,1,0,1 with junk data and stray acks in the gaps.
    set_pattern(3);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (pat[c] == 1) begin
        drive_beat(k);
        load_valid_i = 1'b1;
        result_ack_i = 1'b0;
      end else begin
        load_a_i     = {N{8'hEE}};
        load_b_i     = {N{8'hEE}};
        load_valid_i = 1'b0;
        result_ack_i = 1'b1;
      end
      if (c == 5) check("gap_no_early_stream", mm_valid_o, 0);
      tick();
      if (pat[c] == 1) k++;
    end
    load_valid_i = 1'b0;
    result_ack_i = 1'b0;
    load_a_i     = '0;
    load_b_i     = '0;
    check("gap_stream_start", mm_valid_o, 1);
    finish_job(n);
    check("gap_err_clear", err_o, 0);

    // Engine done pulsed during LOAD: sticky error, job still completes.
    set_pattern(7);
    load_b2b(1);
    finish_job(n);
    check("err_sticky", err_o, 1);

    // Reset asserted at STREAM k=2 acts without a clock edge.
    set_pattern(5);
    load_b2b(-1);
    tick();
    tick();
    check("abort_at_k2_valid", mm_valid_o, 1);
    #1;
    reset_ni = 1'b0;
    #1;
    check("abort_valid", mm_valid_o, 0);
    check("abort_mm_reset", mm_reset_o, 1);
    check("abort_err", err_o, 0);
    check("abort_a", mm_a_o, 0);
    tick();
    tick();
    release_reset();

    // Clean identity job after the abort.
    set_identity();
    load_b2b(-1);
    check("post_abort_a", mm_a_o, 32'h0000_0001);
    finish_job(n);
    check("post_abort_latency", n, 3 * N - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mm_operand_feeder
